// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Single-byte SPI mode 0 (CPOL=0, CPHA=0) master. Shifts a
//                byte out on mosi MSB-first while capturing one from miso.
//                CLK_DIV sets the sck half-period in clk cycles; hold_cs
//                keeps cs_n asserted so several bytes can share one frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       hold_cs,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sck,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   // A 1-bit counter is still needed when CLK_DIV=1 (it simply never leaves 0)
   localparam int               CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_SCK_HI = 3'd2,
      S_SCK_LO = 3'd3,
      S_HOLD   = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] div_q,     div_d;
   logic [2:0]       bit_q,     bit_d;
   logic [7:0]       tx_q,      tx_d;
   logic [7:0]       rx_sh_q,   rx_sh_d;
   logic             hold_q,    hold_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             sck_q,     sck_d;
   logic             cs_n_q,    cs_n_d;
   logic             mosi_q,    mosi_d;
   logic             div_expire;

   assign div_expire = (div_q == C_DIV_LAST);

   // Next-state and registered-output logic for the transfer sequencer
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_sh_d   = rx_sh_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      sck_d     = sck_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tx_d    = tx_data;
               hold_d  = hold_cs;
               rx_sh_d = 8'h00;
               cs_n_d  = 1'b0;
               mosi_d  = tx_data[7];
               busy_d  = 1'b1;
               bit_d   = 3'd7;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            // Even when cs_n was already low from a held frame, the slave
            // still gets a full half-period of mosi setup before sck rises.
            if (div_expire) begin
               sck_d          = 1'b1;
               rx_sh_d[bit_q] = miso;
               state_d        = S_SCK_HI;
            end
         end
         S_SCK_HI: begin
            if (div_expire) begin
               sck_d = 1'b0;
               if (bit_q != 3'd0) begin
                  mosi_d  = tx_q[bit_q - 3'd1];
                  bit_d   = bit_q - 3'd1;
                  state_d = S_SCK_LO;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_SCK_LO: begin
            if (div_expire) begin
               sck_d          = 1'b1;
               rx_sh_d[bit_q] = miso;
               state_d        = S_SCK_HI;
            end
         end
         S_HOLD: begin
            if (div_expire) begin
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               if (hold_q) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  cs_n_d  = 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Keeps cs_n high for a full half-period before a new frame
            if (div_expire) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Half-period divider: restarts on every state change and rests at 0 in IDLE
   always_comb begin
      if ((state_d != state_q) || (state_d == S_IDLE)) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= 3'd0;
         tx_q      <= 8'h00;
         rx_sh_q   <= 8'h00;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= 8'h00;
         sck_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_sh_q   <= rx_sh_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
         sck_q     <= sck_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sck     = sck_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Single-byte SPI mode 0 (CPOL=0, CPHA=0) master that serializes a byte onto MOSI and simultaneously captures a byte from MISO. It sits between the core's register/control logic and an external SPI slave, such as the testbench slave model, and drives sck, cs_n and mosi directly. A programmable divider sets the SCK rate. An optional chip-select hold allows multi-byte transactions under one cs_n assertion.

## Interface
Parameters:
- CLK_DIV, default 2: SCK half-period in clk cycles; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a byte transfer; sampled only while busy=0.
- tx_data  input  8  byte to send MSB-first; latched when start is accepted.
- hold_cs  input  1  latched with start; 1 keeps cs_n low after the byte ends.
- busy  output  1  high from start acceptance until the next start may be accepted.
- done  output  1  one-cycle pulse when rx_data is valid.
- rx_data  output  8  byte received MSB-first; holds its value until the next done.
- sck  output  1  SPI clock; idles low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in; treated as already synchronous to clk.

## Operation
- All outputs are registered. Reset values: busy=0, done=0, rx_data=0x00, sck=0, cs_n=1, mosi=0. Reset also sets FSM=IDLE and the divider and bit counters to 0.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- IDLE + start=1:
  - latch tx_data into the shift register and hold_cs into a flag
  - cs_n<=0, mosi<=tx_data[7], busy<=1, bit counter<=7
  - go to SETUP
- SETUP: sck=0 for CLK_DIV cycles. At expiry: sck<=1, capture miso into rx bit 7, go to SCK_HI.
- SCK_HI: lasts CLK_DIV cycles. At expiry: sck<=0.
  - If bits remain: mosi<=next bit, decrement the bit counter, go to SCK_LO.
  - Otherwise go to HOLD; mosi keeps its last value.
- SCK_LO: lasts CLK_DIV cycles. At expiry: sck<=1, capture miso into the current rx bit, go to SCK_HI.
- HOLD: lasts CLK_DIV cycles. At expiry:
  - rx_data<=shift result, done<=1.
  - If hold_cs=0: cs_n<=1, go to GAP.
  - If hold_cs=1: cs_n stays 0, busy<=0, go to IDLE.
- GAP: cs_n stays high for CLK_DIV cycles, then busy<=0 and go to IDLE. This guarantees the minimum cs_n deassertion time.
- start while busy=1 is ignored; it is not queued.
- Accepting a start while cs_n is already low (after a hold_cs=1 byte): cs_n stays low and the full SETUP phase still runs.
- Reset mid-transfer aborts the byte: cs_n=1 and sck=0 on the reset edge, no done pulse, rx_data=0x00.
- A divider counter counts 0..CLK_DIV-1 and reloads on each state change. The bit counter is 3 bits, counting down from 7 to 0 with no wrap.

## Timing
- Edge numbering: edge 0 is the clk edge that accepts start. With D=CLK_DIV:
  - sck rises at edges (2k+1)·D for k=0..7; miso is captured at those same edges.
  - sck falls at edges (2k+2)·D; mosi changes only on falling edges (and at edge 0).
  - done pulses at edge 17·D, and rx_data updates at that same edge.
- busy falls at edge 18·D when hold_cs=0, or at edge 17·D when hold_cs=1.
- Slave timing:
  - MOSI is stable for D cycles before and after every sck rising edge.
  - MISO is expected to change only after cs_n falls or after sck falls.
- Back-to-back throughput with hold_cs=1: one byte per 17·D+1 cycles.

## Test plan
- Reset: assert rst for 3 cycles mid-transfer. Require all outputs at their reset values one edge later, and no done pulse.
- Loop with the mode-0 dummy slave (always returns 0xA5), D=2, start with tx_data=0x3C. Require:
  - slave rx = 0x3C and master rx_data = 0xA5
  - done at edge 34, cs_n high at edge 34, busy low at edge 36
- Edge count and timing, D=1, tx_data=0x81, miso tied 1. Require:
  - exactly 8 sck rising edges, mosi pattern 1,0,0,0,0,0,0,1
  - rx_data=0xFF, done at edge 17
- hold_cs, D=2, two bytes 0x12 then 0x34 with hold_cs=1 then 0, miso tied 0. Require:
  - cs_n low continuously across both bytes
  - done pulses twice, rx_data=0x00 both times
  - cs_n rises only after the second byte
- start while busy: pulse start again at edge 10. Require it to be ignored, only one done, and tx_data unaffected.
- Min CS gap: start held high continuously with D=3. Require cs_n high for ≥3 cycles between consecutive transactions.
